// File: rtl/acia_rx.sv
// acia_rx: 8N1 asynchronous serial receiver, counterpart of acia_tx.
// One clock (clk), synchronous active-high reset (rst).
// The line is resynchronised, frames are timed with a down-counter that ticks
// at the middle of each symbol, and every byte comes out with a one-cycle strobe.
// A low stop bit raises rx_err, and the receiver then waits for the line to
// go high again before it looks for another start bit.
// Optional build macro ACIA_RX_MAJORITY_EN: each mid-symbol decision takes a
// 2-of-3 vote over three consecutive samples centred on the tick.
module acia_rx #(
    parameter int SCW     = 16,     // rate counter width, 2^SCW > sym_cnt
    parameter int sym_cnt = 40000   // clocks per symbol, minimum 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_serial,
    output logic [7:0] rx_dat,
    output logic       rx_stb,
    output logic       rx_err,
    output logic       rx_busy
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_BREAK = 3'd4;

    // Reload values. The half-symbol load puts the first tick in the middle
    // of the start bit; every later tick is one full symbol on from it.
    localparam logic [SCW-1:0] HALF_LD = SCW'(sym_cnt / 2 - 1);
    localparam logic [SCW-1:0] FULL_LD = SCW'(sym_cnt - 1);

    logic           s1;
    logic           sdat;
    logic           samp;
    logic [2:0]     state;
    logic [SCW-1:0] cnt;
    logic [2:0]     idx;
    logic [7:0]     shreg;
    logic           tick;

    // Two-flop synchronizer; both flops reset to the idle (high) level.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1   <= 1'b1;
            sdat <= 1'b1;
        end else begin
            s1   <= rx_serial;
            sdat <= s1;
        end
    end

`ifdef ACIA_RX_MAJORITY_EN
    logic sdat_d;

    // One cycle of history. With s1 (one cycle ahead of sdat) this gives
    // three consecutive samples centred on the tick, and the decision still
    // happens on the tick cycle.
    always_ff @(posedge clk) begin
        if (rst) sdat_d <= 1'b1;
        else     sdat_d <= sdat;
    end

    assign samp = (s1 & sdat) | (s1 & sdat_d) | (sdat & sdat_d);
`else
    assign samp = sdat;
`endif

    assign tick = (cnt == '0);

    // Frame FSM, rate counter, shift register and output strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            idx     <= 3'd0;
            shreg   <= 8'h00;
            rx_dat  <= 8'h00;
            rx_stb  <= 1'b0;
            rx_err  <= 1'b0;
            rx_busy <= 1'b0;
        end else begin
            rx_stb <= 1'b0;
            rx_err <= 1'b0;
            // The counter only runs while a frame is being timed. On a tick it
            // is reloaded by the state logic below, or it stays at zero.
            if ((state == ST_START || state == ST_DATA || state == ST_STOP) && !tick)
                cnt <= cnt - 1'b1;
            case (state)
                ST_IDLE: begin
                    // Edge detection uses the single synchronised sample.
                    if (!sdat) begin
                        cnt     <= HALF_LD;
                        state   <= ST_START;
                        rx_busy <= 1'b1;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        if (samp) begin
                            // Line went high again by mid start bit: a glitch.
                            state   <= ST_IDLE;
                            rx_busy <= 1'b0;
                        end else begin
                            cnt   <= FULL_LD;
                            idx   <= 3'd0;
                            state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        // LSB arrives first, so shift in at the MSB side.
                        shreg <= {samp, shreg[7:1]};
                        cnt   <= FULL_LD;
                        idx   <= idx + 3'd1;
                        if (idx == 3'd7) state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        if (samp) begin
                            // Leave mid stop bit so a start bit right after it
                            // is still caught.
                            rx_dat  <= shreg;
                            rx_stb  <= 1'b1;
                            state   <= ST_IDLE;
                            rx_busy <= 1'b0;
                        end else begin
                            rx_err <= 1'b1;
                            state  <= ST_BREAK;
                        end
                    end
                end
                ST_BREAK: begin
                    // A line held low must not start a new frame.
                    if (sdat) begin
                        state   <= ST_IDLE;
                        rx_busy <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_acia_rx.sv
// Testbench for acia_rx at 16 clocks per symbol. A line driver sends 8N1 frames.
// A posedge monitor records strobes, errors and rx_dat behaviour. Each test task
// compares what came out with the frames it sent.
module tb_acia_rx;

    localparam int SYM = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx_serial = 1'b1;
    logic [7:0] rx_dat;
    logic       rx_stb;
    logic       rx_err;
    logic       rx_busy;

    int n_chk  = 0;
    int n_pass = 0;

    acia_rx #(.SCW(16), .sym_cnt(SYM)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_serial (rx_serial),
        .rx_dat    (rx_dat),
        .rx_stb    (rx_stb),
        .rx_err    (rx_err),
        .rx_busy   (rx_busy)
    );

    always #5 clk = ~clk;

    // Monitor state, sampled 2 time units after each rising edge.
    logic [7:0] rxq[$];
    int         rxt[$];
    int         n_err = 0;
    int         cyc = 0;
    bit         both_hi = 0;
    bit         dat_glitch = 0;
    bit         busy_low = 0;
    logic [7:0] prev_dat = 8'h00;

    always @(posedge clk) begin
        #2;
        cyc++;
        if (rx_stb) begin
            rxq.push_back(rx_dat);
            rxt.push_back(cyc);
        end
        if (rx_err) n_err++;
        if (rx_stb && rx_err) both_hi = 1;
        if (!rst && !rx_stb && rx_dat !== prev_dat) dat_glitch = 1;
        prev_dat = rx_dat;
    end

    task automatic clear_mon();
        rxq.delete();
        rxt.delete();
        n_err = 0;
        busy_low = 0;
    endtask

    task automatic idle(input int n);
        rx_serial = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Drive one frame from the current falling edge: start, 8 data bits LSB
    // first, stop. With spike set, data and stop bits are inverted for the
    // single clock around their centre. rx_busy must stay high from a few
    // clocks into the start bit until the stop bit begins.
    task automatic send_frame(input logic [7:0] b, input bit stop, input bit spike,
                              output int t0);
        logic [9:0] f;
        f  = {stop, b, 1'b0};
        t0 = cyc;
        for (int i = 0; i < 10; i++) begin
            for (int c = 0; c < SYM; c++) begin
                if ((i * SYM + c) >= 4 && (i * SYM + c) < 9 * SYM && !rx_busy) busy_low = 1;
                rx_serial = f[i] ^ (spike && i > 0 && c == SYM / 2);
                @(negedge clk);
            end
        end
        rx_serial = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++; if (rx_dat !== 8'h00) $display("FAIL reset_dat got %h want 00", rx_dat); else n_pass++;
        n_chk++; if (rx_stb !== 1'b0)  $display("FAIL reset_stb got %b want 0", rx_stb); else n_pass++;
        n_chk++; if (rx_err !== 1'b0)  $display("FAIL reset_err got %b want 0", rx_err); else n_pass++;
        n_chk++; if (rx_busy !== 1'b0) $display("FAIL reset_busy got %b want 0", rx_busy); else n_pass++;
        rst = 1'b0;
        idle(5);
    endtask

    // 0x53 then random bytes with random idle gaps; checks data, latency, busy.
    task automatic test_single();
        logic [7:0] b[5];
        int         t[5];
        int         lat;
        clear_mon();
        for (int i = 0; i < 5; i++) begin
            b[i] = (i == 0) ? 8'h53 : 8'($urandom);
            send_frame(b[i], 1'b1, 1'b0, t[i]);
            idle($urandom_range(0, 20));
        end
        idle(40);
        n_chk++; if (rxq.size() != 5) $display("FAIL single_count got %0d want 5", rxq.size()); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            if (i < rxq.size()) begin
                lat = rxt[i] - t[i];
                n_chk++; if (rxq[i] !== b[i]) $display("FAIL single_dat%0d got %h want %h", i, rxq[i], b[i]); else n_pass++;
                n_chk++; if (lat < 153 || lat > 155) $display("FAIL single_lat%0d got %0d want 153..155", i, lat); else n_pass++;
            end
        end
        n_chk++; if (n_err != 0) $display("FAIL single_err got %0d want 0", n_err); else n_pass++;
        n_chk++; if (busy_low) $display("FAIL single_busy got low want high in frame"); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] b[6];
        int         t;
        clear_mon();
        b[0] = 8'h00; b[1] = 8'hFF; b[2] = 8'hA5;
        for (int i = 3; i < 6; i++) b[i] = 8'($urandom);
        for (int i = 0; i < 6; i++) send_frame(b[i], 1'b1, 1'b0, t);
        idle(40);
        n_chk++; if (rxq.size() != 6) $display("FAIL b2b_count got %0d want 6", rxq.size()); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            if (i < rxq.size()) begin
                n_chk++; if (rxq[i] !== b[i]) $display("FAIL b2b_dat%0d got %h want %h", i, rxq[i], b[i]); else n_pass++;
            end
        end
        n_chk++; if (n_err != 0) $display("FAIL b2b_err got %0d want 0", n_err); else n_pass++;
        n_chk++; if (busy_low) $display("FAIL b2b_busy got low want high in frame"); else n_pass++;
    endtask

    task automatic test_glitch();
        bit seen_busy;
        clear_mon();
        seen_busy = 0;
        rx_serial = 1'b0;
        repeat (4) @(negedge clk);
        rx_serial = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (rx_busy) seen_busy = 1;
            @(negedge clk);
        end
        n_chk++; if (!seen_busy) $display("FAIL glitch_busy_set got 0 want 1"); else n_pass++;
        n_chk++; if (rx_busy !== 1'b0) $display("FAIL glitch_busy_clr got %b want 0", rx_busy); else n_pass++;
        idle(200);
        n_chk++; if (rxq.size() != 0) $display("FAIL glitch_stb got %0d want 0", rxq.size()); else n_pass++;
        n_chk++; if (n_err != 0) $display("FAIL glitch_err got %0d want 0", n_err); else n_pass++;
    endtask

    task automatic test_break();
        logic [7:0] prev;
        int         t;
        prev = 8'($urandom_range(1, 255));
        send_frame(prev, 1'b1, 1'b0, t);
        idle(20);
        clear_mon();
        send_frame(8'h3C, 1'b0, 1'b0, t);
        rx_serial = 1'b0;
        repeat (40 - SYM) @(negedge clk);
        n_chk++; if (n_err != 1) $display("FAIL break_err got %0d want 1", n_err); else n_pass++;
        n_chk++; if (rxq.size() != 0) $display("FAIL break_stb got %0d want 0", rxq.size()); else n_pass++;
        n_chk++; if (rx_dat !== prev) $display("FAIL break_dat got %h want %h", rx_dat, prev); else n_pass++;
        n_chk++; if (rx_busy !== 1'b1) $display("FAIL break_busy got %b want 1", rx_busy); else n_pass++;
        idle(SYM);
        n_chk++; if (rx_busy !== 1'b0) $display("FAIL break_release got %b want 0", rx_busy); else n_pass++;
        send_frame(8'h3C, 1'b1, 1'b0, t);
        idle(40);
        n_chk++; if (rxq.size() != 1) $display("FAIL break_next_count got %0d want 1", rxq.size()); else n_pass++;
        if (rxq.size() > 0) begin
            n_chk++; if (rxq[0] !== 8'h3C) $display("FAIL break_next_dat got %h want 3c", rxq[0]); else n_pass++;
        end
        n_chk++; if (n_err != 1) $display("FAIL break_next_err got %0d want 1", n_err); else n_pass++;
    endtask

    // Reset during data bit 4 of 0x77. The rest of that frame can look like a
    // new start bit to the receiver, so let the line settle before 0x12 goes out.
    task automatic test_reset_mid();
        int  t;
        bit  hit77;
        send_frame(8'hC3, 1'b1, 1'b0, t);
        idle(20);
        clear_mon();
        fork
            send_frame(8'h77, 1'b1, 1'b0, t);
            begin
                repeat (5 * SYM + SYM / 2) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                n_chk++; if (rx_dat !== 8'h00) $display("FAIL rmid_dat got %h want 00", rx_dat); else n_pass++;
                n_chk++; if (rx_busy !== 1'b0) $display("FAIL rmid_busy got %b want 0", rx_busy); else n_pass++;
                n_chk++; if (rx_stb !== 1'b0 || rx_err !== 1'b0)
                    $display("FAIL rmid_pulse got stb=%b err=%b want 0 0", rx_stb, rx_err); else n_pass++;
            end
        join
        idle(12 * SYM);
        hit77 = 0;
        foreach (rxq[i]) if (rxq[i] == 8'h77) hit77 = 1;
        n_chk++; if (hit77) $display("FAIL rmid_aborted got 77 want none"); else n_pass++;
        clear_mon();
        send_frame(8'h12, 1'b1, 1'b0, t);
        idle(40);
        n_chk++; if (rxq.size() != 1) $display("FAIL rmid_next_count got %0d want 1", rxq.size()); else n_pass++;
        if (rxq.size() > 0) begin
            n_chk++; if (rxq[0] !== 8'h12) $display("FAIL rmid_next_dat got %h want 12", rxq[0]); else n_pass++;
        end
        n_chk++; if (n_err != 0) $display("FAIL rmid_err got %0d want 0", n_err); else n_pass++;
    endtask

    // 0x55 with a one-clock inverted spike at the centre of every data and
    // stop bit. The vote rejects it; a single sample sees inverted bits and a
    // low stop bit.
    task automatic test_majority();
        int t;
        clear_mon();
        send_frame(8'h55, 1'b1, 1'b1, t);
        idle(60);
`ifdef ACIA_RX_MAJORITY_EN
        n_chk++; if (rxq.size() != 1) $display("FAIL maj_count got %0d want 1", rxq.size()); else n_pass++;
        if (rxq.size() > 0) begin
            n_chk++; if (rxq[0] !== 8'h55) $display("FAIL maj_dat got %h want 55", rxq[0]); else n_pass++;
        end
        n_chk++; if (n_err != 0) $display("FAIL maj_err got %0d want 0", n_err); else n_pass++;
`else
        n_chk++; if (rxq.size() != 0) $display("FAIL spike_stb got %0d want 0", rxq.size()); else n_pass++;
        n_chk++; if (n_err != 1) $display("FAIL spike_err got %0d want 1", n_err); else n_pass++;
`endif
        n_chk++; if (rx_busy !== 1'b0) $display("FAIL spike_busy got %b want 0", rx_busy); else n_pass++;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_break();
        test_reset_mid();
        test_majority();
        n_chk++; if (both_hi) $display("FAIL stb_err_overlap got 1 want 0"); else n_pass++;
        n_chk++; if (dat_glitch) $display("FAIL dat_stable got change want none"); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
